freq_comp_seq: RTL
==================

Name: freq_comp_seq

Overview:
Sequencer that streams frequency-compensation factors out of the 9000-entry compensation ROM (14-bit address, 26-bit data, combinational read) for one DFT block at a time. Given a table base address and block length, it walks the ROM sequentially and registers each factor. It presents the factors to the post-processing multiplier over a valid/ready stream with backpressure. It also checks the configuration against ROM bounds and reports block completion.

Parameters:
AW, 14, ROM address width
DW, 26, ROM data / factor width
LW, 11, block-length width (max length 2047)
ROM_DEPTH, 9000, number of valid ROM entries (addresses 0..ROM_DEPTH-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  1-cycle request to begin a block; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE
base_addr  in  AW  first ROM address of the table; sampled with start
blk_len  in  LW  number of factors to emit; sampled with start
rom_addr  out  AW  address to compensation ROM
rom_data  in  DW  ROM read data, valid in the same cycle as rom_addr
comp_valid  out  1  comp_data holds a factor
comp_ready  in  1  downstream accepts the factor
comp_data  out  DW  registered compensation factor
comp_idx  out  LW  index of the factor within the block (0..blk_len-1)
comp_last  out  1  high with the final factor of the block
busy  out  1  high in RUN and FLUSH
done  out  1  1-cycle pulse after the last factor is accepted
cfg_err  out  1  1-cycle pulse when a start is rejected

Behaviour:
- Reset: rom_addr=0, comp_valid=0, comp_data=0, comp_idx=0, comp_last=0, busy=0, done=0, cfg_err=0; state=IDLE.
- A "beat" is a cycle with comp_valid && comp_ready.
- An output load occurs when the state is RUN and (!comp_valid || comp_ready).
- FSM states are IDLE, RUN and FLUSH.
- IDLE, start=1, config check:
  - Reject if blk_len==0, or if base_addr+blk_len > ROM_DEPTH. Compute the sum at AW+1 bits, with no wrap.
  - On reject: pulse cfg_err next cycle, stay IDLE, leave rom_addr unchanged.
  - On accept: latch base/len, set rom_addr=base_addr and remaining=blk_len, go to RUN.
- RUN:
  - On each output load: comp_data<=rom_data, comp_idx<=running index, comp_last<=(remaining==1), comp_valid<=1.
  - Also on each load: rom_addr increments and remaining decrements.
  - The load that consumes remaining==1 moves to FLUSH. rom_addr then holds the last address and does not step past the table.
- FLUSH: no further loads. On the beat with comp_last=1: comp_valid<=0, comp_last<=0, go to IDLE, and pulse done in the following cycle (the first IDLE cycle).
- While waiting: if comp_ready=0, comp_data, comp_idx and comp_last hold. Throughput is one factor per cycle while comp_ready=1.
- Latency: start accepted at cycle T gives rom_addr=base at T+1 and the first comp_valid at T+2.
- A blk_len=1 block emits a single beat with comp_idx=0 and comp_last=1.
- busy is high from T+1 until the cycle before done. A start in the cycle done is high is accepted.
- start while busy is ignored: no cfg_err, and the running block is unaffected.
- abort in any state:
  - Next cycle: IDLE, comp_valid=0, comp_last=0, busy=0; done and cfg_err are not pulsed.
  - rom_addr holds its value. A beat in the abort cycle still counts downstream.
  - abort and start in the same cycle: abort wins and start is ignored.
- rst mid-block: identical to the reset state, no done pulse.
- comp_idx counts 0..blk_len-1 with no wrap, since blk_len ≤ 2^LW-1.

Test Plan:
- Basic: base=100, len=4, comp_ready=1 → comp_valid T+2..T+5; comp_data=ROM[100..103]; comp_idx 0..3; comp_last on idx 3; done at T+6; busy T+1..T+5.
- Backpressure: base=0, len=3, comp_ready low for 3 cycles on idx 1 → idx 1 data stable and held; no duplicated or skipped factor; total 3 beats; done after the idx 2 beat.
- Bounds: base=8996, len=4 → accepted, last factor ROM[8999]. base=8997, len=4 → cfg_err pulse, busy stays 0. len=0 → cfg_err.
- Single/back-to-back: len=1 → one beat with idx 0 and last=1. A start in the done cycle with base=50, len=2 → accepted, ROM[50], ROM[51] streamed.
- Abort: base=200, len=10, abort after 3rd beat → comp_valid=0 next cycle, no done pulse, a new start succeeds.
- Ignore/reset: start while busy → ignored with no cfg_err. rst mid-block → all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/freq_comp_seq_if.sv
// rtl/freq_comp_seq_if.sv - compensation-factor stream between sequencer and multiplier
//
// Purpose: carries one compensation factor per beat with valid/ready backpressure.
// Signals:
//   comp_valid  comp_data holds a factor           (master -> slave)
//   comp_ready  slave accepts the factor           (slave  -> master)
//   comp_data   compensation factor, DW bits       (master -> slave)
//   comp_idx    factor index within the block      (master -> slave)
//   comp_last   final factor of the block          (master -> slave)
interface freq_comp_seq_if #(
    parameter int DW = 26,
    parameter int LW = 11
);
    logic          comp_valid;
    logic          comp_ready;
    logic [DW-1:0] comp_data;
    logic [LW-1:0] comp_idx;
    logic          comp_last;

    modport master (
        output comp_valid,
        output comp_data,
        output comp_idx,
        output comp_last,
        input  comp_ready
    );

    modport slave (
        input  comp_valid,
        input  comp_data,
        input  comp_idx,
        input  comp_last,
        output comp_ready
    );
endinterface

// File: rtl/freq_comp_seq.sv
// rtl/freq_comp_seq.sv - streams compensation factors from the ROM for one DFT block
//
// Purpose: walks the compensation ROM from base_addr for blk_len entries, registers
// each factor and presents it on a valid/ready stream; rejects out-of-range blocks.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, abort      begin a block (IDLE only) / return to IDLE
//   base_addr,blk_len block configuration, sampled with start
//   rom_addr,rom_data combinational ROM read port
//   comp              factor stream (master side)
//   busy              block in progress
//   done              one-cycle pulse after the last factor is accepted
//   cfg_err           one-cycle pulse when a start is rejected
module freq_comp_seq #(
    parameter int AW        = 14,
    parameter int DW        = 26,
    parameter int LW        = 11,
    parameter int ROM_DEPTH = 9000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [AW-1:0]         base_addr,
    input  logic [LW-1:0]         blk_len,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_data,
    freq_comp_seq_if.master       comp,
    output logic                  busy,
    output logic                  done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    localparam logic [AW:0] DEPTH_LIM = (AW+1)'(ROM_DEPTH);

    state_t        state;
    logic [LW-1:0] remaining;
    logic [LW-1:0] idx;
    logic [AW:0]   cfg_end;
    logic          cfg_bad;
    logic          load;

    // One extra bit so base+len can never wrap back into range.
    assign cfg_end = {1'b0, base_addr} + (AW+1)'(blk_len);
    assign cfg_bad = (blk_len == '0) || (cfg_end > DEPTH_LIM);

    // The output register refills whenever it is empty or being drained this cycle.
    assign load = (state == RUN) && (!comp.comp_valid || comp.comp_ready);

    // rom_addr and remaining double as the latched block configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            rom_addr        <= '0;
            remaining       <= '0;
            idx             <= '0;
            comp.comp_valid <= 1'b0;
            comp.comp_data  <= '0;
            comp.comp_idx   <= '0;
            comp.comp_last  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            cfg_err         <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            if (abort) begin
                state           <= IDLE;
                comp.comp_valid <= 1'b0;
                comp.comp_last  <= 1'b0;
                busy            <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (cfg_bad) begin
                                cfg_err <= 1'b1;
                            end else begin
                                rom_addr  <= base_addr;
                                remaining <= blk_len;
                                idx       <= '0;
                                busy      <= 1'b1;
                                state     <= RUN;
                            end
                        end
                    end
                    RUN: begin
                        if (load) begin
                            comp.comp_data  <= rom_data;
                            comp.comp_idx   <= idx;
                            comp.comp_last  <= (remaining == LW'(1));
                            comp.comp_valid <= 1'b1;
                            idx             <= idx + LW'(1);
                            // Last fetch: keep rom_addr on the final table entry.
                            if (remaining == LW'(1)) begin
                                state <= FLUSH;
                            end else begin
                                rom_addr  <= rom_addr + AW'(1);
                                remaining <= remaining - LW'(1);
                            end
                        end
                    end
                    FLUSH: begin
                        if (comp.comp_valid && comp.comp_ready && comp.comp_last) begin
                            comp.comp_valid <= 1'b0;
                            comp.comp_last  <= 1'b0;
                            busy            <= 1'b0;
                            done            <= 1'b1;
                            state           <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
